cordic_row_sequencer: RTL

CORDIC_ROW_SEQUENCER -- requirements
Module: cordic_row_sequencer

---
 rtl/cordic_row_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/cordic_row_sequencer.sv
// rtl/cordic_row_sequencer.sv - CORDIC micro-rotation sequencer applying one shared direction to a packed H row and a Y element
`ifndef WL
`define WL 16
`endif

module cordic_row_sequencer #(
  parameter int N    = 2,
  parameter int ITER = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [`WL*N-1:0]  hin_x,
  input  logic [`WL*N-1:0]  hin_y,
  input  logic [`WL-1:0]    yin_x,
  input  logic [`WL-1:0]    yin_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [`WL*N-1:0]  hout_x,
  output logic [`WL*N-1:0]  hout_y,
  output logic [`WL-1:0]    yout_x,
  output logic [`WL-1:0]    yout_y,
  output logic              busy
);

  localparam int WL = `WL;
  localparam int KW = (WL > 1) ? $clog2(WL) : 1;

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t                 state_q;
  logic [KW-1:0]          k_q;
  logic [N-1:0][WL-1:0]   hx_q, hy_q, hx_d, hy_d;
  logic [WL-1:0]          yx_q, yy_q, yx_d, yy_d;
  logic                   dir;

  // One micro-rotation; sums wrap to WL bits, shifts floor toward minus infinity.
  function automatic logic [2*WL-1:0] micro_rot(input logic [WL-1:0] x,
                                                input logic [WL-1:0] y,
                                                input logic [KW-1:0] k,
                                                input logic          d);
    logic signed [WL-1:0] xs, ys;
    logic [WL-1:0]        xn, yn;
    xs = $signed(x) >>> k;
    ys = $signed(y) >>> k;
    if (d) begin
      xn = x + ys;
      yn = y - xs;
    end else begin
      xn = x - ys;
      yn = xs + y;
    end
    return {yn, xn};
  endfunction

  // Element 0 steers every rotation in the row; y0 == 0 counts as non-negative.
  always_comb begin
    dir  = ~hy_q[0][WL-1];
    hx_d = hx_q;
    hy_d = hy_q;
    for (int i = 0; i < N; i++) begin
      {hy_d[i], hx_d[i]} = micro_rot(hx_q[i], hy_q[i], k_q, dir);
    end
    {yy_d, yx_d} = micro_rot(yx_q, yy_q, k_q, dir);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      hx_q    <= '0;
      hy_q    <= '0;
      yx_q    <= '0;
      yy_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hx_q    <= hin_x;
            hy_q    <= hin_y;
            yx_q    <= yin_x;
            yy_q    <= yin_y;
            k_q     <= '0;
            state_q <= ROTATE;
          end
        end
        ROTATE: begin
          hx_q <= hx_d;
          hy_q <= hy_d;
          yx_q <= yx_d;
          yy_q <= yy_d;
          k_q  <= k_q + 1'b1;
          if (k_q == KW'(ITER - 1)) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ROTATE);
  assign hout_x    = hx_q;
  assign hout_y    = hy_q;
  assign yout_x    = yx_q;
  assign yout_y    = yy_q;

endmodule
